// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, defaults and entry type for the write-back arbiter
package wb_arbiter_pkg;

  localparam int WB_DEPTH_DEF        = 2;
  localparam int WB_STARVE_LIMIT_DEF = 4;
  localparam int ADDR_W              = 5;
  localparam int DATA_W              = 32;
  localparam int ENTRY_W             = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_entry_t;

  function automatic wb_entry_t wb_pack(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_entry_t e;
    e.waddr = a;
    e.wdata = d;
    return e;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order buffer for long-latency write-back results
module wb_fifo #(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 37,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  // Guard against caller misuse so occupancy can never over- or under-flow.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rptr_q];
  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter between pipeline and long-latency results
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = WB_DEPTH_DEF,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_waddr,
  input  logic [DATA_W-1:0] md_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              stall_req
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t         head;
  logic              full, empty, push, pop;
  logic [CW-1:0]     count;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;

  assign md_ready = ~full;
  // Writes to r0 are handshaken but never buffered.
  assign push     = md_valid & md_ready & (md_waddr != '0);
  assign pop      = ~pipe_valid & ~empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push),
    .push_data_i (wb_pack(md_waddr, md_wdata)),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  always_comb begin
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    if (pipe_valid) begin
      if (pipe_waddr != '0) begin
        we_d    = 1'b1;
        waddr_d = pipe_waddr;
        wdata_d = pipe_wdata;
      end
    end else if (!empty) begin
      we_d    = 1'b1;
      waddr_d = head.waddr;
      wdata_d = head.wdata;
    end

    // Non-empty and not popping implies the pipeline took the port.
    starve_d = starve_q;
    if (empty || pop)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;

    stall_d = (starve_q == SW'(STARVE_LIMIT)) || (count == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        resetn;
  logic        pipe_valid;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_waddr;
  logic [31:0] md_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall_req;

  wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pipe_valid (pipe_valid),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_waddr   (md_waddr),
    .md_wdata   (md_wdata),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .stall_req  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          m_starve;
  bit          m_stall;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          accepted;
  int          n_chk, n_err, n_viol;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_starve = 0;
    m_stall  = 0;
    m_we     = 0;
    m_waddr  = '0;
    m_wdata  = '0;
  endtask

  // One clock of behaviour, from the current inputs and the model's visible state.
  task automatic model_advance();
    int  occ;
    bit  do_pop, do_push;
    occ      = q.size();
    accepted = md_valid && (occ < DEPTH);
    do_push  = accepted && (md_waddr != 0);
    do_pop   = !pipe_valid && (occ > 0);
    if (pipe_valid && m_stall) n_viol++;

    if (pipe_valid) begin
      m_we    = (pipe_waddr != 0);
      m_waddr = pipe_waddr;
      m_wdata = pipe_wdata;
    end else if (occ > 0) begin
      m_we    = 1;
      m_waddr = q[0].a;
      m_wdata = q[0].d;
    end else begin
      m_we = 0;
    end

    m_stall = (m_starve == STARVE_LIMIT) || (occ == DEPTH);
    if (occ == 0 || do_pop) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve++;

    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{a: md_waddr, d: md_wdata});
  endtask

  task automatic check_outputs();
    chk("we", {31'd0, we}, {31'd0, m_we});
    if (m_we) begin
      chk("waddr", {27'd0, waddr}, {27'd0, m_waddr});
      chk("wdata", wdata, m_wdata);
    end
    chk("md_ready", {31'd0, md_ready}, {31'd0, q.size() < DEPTH});
    chk("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
  endtask

  task automatic step();
    model_advance();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    pipe_valid = 0; pipe_waddr = '0; pipe_wdata = '0;
    md_valid   = 0; md_waddr   = '0; md_wdata   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 resetn = 1'b0;
    #1;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk("rst_md_ready", {31'd0, md_ready}, 32'd1);
  endtask

  task automatic set_pipe(input bit v, input logic [4:0] a, input logic [31:0] d);
    pipe_valid = v; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic set_md(input bit v, input logic [4:0] a, input logic [31:0] d);
    md_valid = v; md_waddr = a; md_wdata = d;
  endtask

  initial begin
    n_chk = 0; n_err = 0; n_viol = 0;
    idle_inputs();
    model_reset();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("init_we", {31'd0, we}, 32'd0);
    chk("init_stall", {31'd0, stall_req}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_outputs();

    // Single pipeline write, then idle.
    set_pipe(1, 5'd3, 32'h11);
    step();
    chk("lit_pipe_we", {31'd0, we}, 32'd1);
    chk("lit_pipe_waddr", {27'd0, waddr}, 32'd3);
    chk("lit_pipe_wdata", wdata, 32'h11);
    set_pipe(0, '0, '0);
    step();
    chk("lit_pipe_we_off", {31'd0, we}, 32'd0);

    // Back-to-back long-latency results drain in order.
    set_md(1, 5'd5, 32'hA); step();
    set_md(1, 5'd6, 32'hB); step();
    chk("lit_md_r5", {27'd0, waddr}, 32'd5);
    chk("lit_md_r5_d", wdata, 32'hA);
    set_md(0, '0, '0); step();
    chk("lit_md_r6", {27'd0, waddr}, 32'd6);
    chk("lit_md_r6_d", wdata, 32'hB);
    step();
    chk("lit_md_idle", {31'd0, we}, 32'd0);

    // Starvation: r7 buffered while the pipeline keeps the port.
    set_md(1, 5'd7, 32'h7); step();
    set_md(0, '0, '0);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      set_pipe(1, 5'd9, 32'h90 + i);
      step();
    end
    chk("lit_starve_pre", {31'd0, stall_req}, 32'd0);
    step();
    chk("lit_starve_stall", {31'd0, stall_req}, 32'd1);
    set_pipe(0, '0, '0); step();
    chk("lit_starve_r7", {27'd0, waddr}, 32'd7);
    chk("lit_starve_r7_we", {31'd0, we}, 32'd1);
    step();
    chk("lit_starve_clr", {31'd0, stall_req}, 32'd0);

    // Fill while the pipeline holds the port; third result waits for space.
    set_pipe(1, 5'd10, 32'hA0);
    set_md(1, 5'd1, 32'h1); step();
    set_md(1, 5'd2, 32'h2); step();
    chk("lit_full_ready", {31'd0, md_ready}, 32'd0);
    set_md(1, 5'd3, 32'h3); step();
    chk("lit_full_stall", {31'd0, stall_req}, 32'd1);
    set_pipe(0, '0, '0);
    for (int i = 0; i < 8 && md_valid; i++) begin
      step();
      if (accepted) set_md(0, '0, '0);
    end
    chk("lit_third_accepted", {31'd0, md_valid}, 32'd0);
    for (int i = 0; i < 4; i++) step();

    // r0 from the long-latency side: handshake only, occupancy unchanged.
    set_pipe(1, 5'd11, 32'hB0);
    set_md(1, 5'd12, 32'hC); step();
    set_md(1, 5'd0, 32'hDEAD); step();
    chk("lit_r0_ready", {31'd0, md_ready}, 32'd1);
    set_md(0, '0, '0);
    set_pipe(1, 5'd0, 32'hFFFF); step();
    chk("lit_pipe_r0_we", {31'd0, we}, 32'd0);
    set_pipe(0, '0, '0);
    for (int i = 0; i < 3; i++) step();

    // Reset with two entries buffered.
    set_pipe(1, 5'd13, 32'hD0);
    set_md(1, 5'd14, 32'hE); step();
    set_md(1, 5'd15, 32'hF); step();
    do_reset();
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic, mostly honouring stall_req.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        pipe_valid = ($urandom_range(0, 99) < (m_stall ? 10 : 45));
        pipe_waddr = 5'($urandom_range(0, 31));
        pipe_wdata = $urandom;
        if (!md_valid || accepted || $urandom_range(0, 3) == 0) begin
          md_valid = ($urandom_range(0, 99) < 55);
          md_waddr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          md_wdata = $urandom;
        end
        step();
      end
    end

    $display("note: %0d cycles had pipe_valid during stall_req", n_viol);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
